// File: rtl/memtest_march_engine_pkg.sv
// ----------------------------------------------------------------------------
// memtest_march_engine_pkg
// Shared definitions for the March C- memory test engine. It holds the default
// geometry, the FSM state encoding, and the march element table (sweep
// direction, read/write operations and element code for each state).
// ----------------------------------------------------------------------------
package memtest_march_engine_pkg;

    localparam int ADDR_BITS_DEF = 4;
    localparam int DATA_BITS_DEF = 8;
    localparam int CNT_BITS_DEF  = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_E0    = 4'd1,
        ST_E1    = 4'd2,
        ST_E2    = 4'd3,
        ST_E3    = 4'd4,
        ST_E4    = 4'd5,
        ST_E5    = 4'd6,
        ST_FLUSH = 4'd7,
        ST_FIN   = 4'd8
    } state_t;

    // One march element: a sweep direction plus an optional read and an
    // optional write. The *_inv flags select ~bg ("1") instead of bg ("0").
    typedef struct packed {
        logic       down;
        logic       has_rd;
        logic       rd_inv;
        logic       has_wr;
        logic       wr_inv;
        logic [2:0] code;
    } elem_op_t;

    function automatic elem_op_t elem_op(input state_t st);
        elem_op_t op;
        case (st)
            ST_E0:   op = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}; // up   w0
            ST_E1:   op = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1}; // up   r0,w1
            ST_E2:   op = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2}; // up   r1,w0
            ST_E3:   op = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3}; // down r0,w1
            ST_E4:   op = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4}; // down r1,w0
            ST_E5:   op = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5}; // up   r0
            default: op = '0;
        endcase
        return op;
    endfunction

    function automatic state_t next_elem(input state_t st);
        case (st)
            ST_E0:   return ST_E1;
            ST_E1:   return ST_E2;
            ST_E2:   return ST_E3;
            ST_E3:   return ST_E4;
            ST_E4:   return ST_E5;
            default: return ST_FLUSH;
        endcase
    endfunction

endpackage

// File: rtl/memtest_march_engine_if.sv
// ----------------------------------------------------------------------------
// memtest_march_engine_if
// Host-side bundle of the memory test engine.
//   master: drives start/bg/inj_* (BIST launch) and dir_* (direct access),
//           observes rdata and the BIST status outputs.
//   slave : the engine itself.
// ----------------------------------------------------------------------------
interface memtest_march_engine_if #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8,
    parameter int CNT_BITS  = 8
);
    logic                 start;
    logic [DATA_BITS-1:0] bg;
    logic                 inj_en;
    logic [ADDR_BITS-1:0] inj_addr;
    logic                 dir_we;
    logic [ADDR_BITS-1:0] dir_addr;
    logic [DATA_BITS-1:0] dir_wdata;
    logic [DATA_BITS-1:0] rdata;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_BITS-1:0]  fail_count;
    logic [ADDR_BITS-1:0] first_fail_addr;
    logic [2:0]           first_fail_elem;

    modport master (
        output start, bg, inj_en, inj_addr, dir_we, dir_addr, dir_wdata,
        input  rdata, busy, done, pass, fail_count, first_fail_addr, first_fail_elem
    );

    modport slave (
        input  start, bg, inj_en, inj_addr, dir_we, dir_addr, dir_wdata,
        output rdata, busy, done, pass, fail_count, first_fail_addr, first_fail_elem
    );
endinterface

// File: rtl/memtest_march_engine_mem_array.sv
// ----------------------------------------------------------------------------
// memtest_march_engine_mem_array
// Register-file array: synchronous write, registered read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, addr, wdata : write port (shared address with read)
//   rdata      : mem[addr] one cycle after addr is presented
// The storage itself has no reset.
// ----------------------------------------------------------------------------
module memtest_march_engine_mem_array #(
    parameter int ADDR_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read-before-write on a same-cycle collision; a write in the previous
    // cycle is already visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= mem[addr];
    end

endmodule

// File: rtl/memtest_march_engine.sv
// ----------------------------------------------------------------------------
// memtest_march_engine
// Memory array wrapper with direct host access and a March C- BIST engine.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): start/bg/inj_en/inj_addr launch a BIST run from IDLE;
//                dir_we/dir_addr/dir_wdata give direct access in IDLE;
//                rdata is the registered array read port;
//                busy/done/pass/fail_count/first_fail_* report the run.
// ----------------------------------------------------------------------------
module memtest_march_engine
    import memtest_march_engine_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    memtest_march_engine_if.slave bus
);

    state_t               state, state_nxt;
    elem_op_t             op, op_nxt;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 phase_q;
    logic [DATA_BITS-1:0] bg_q;
    logic                 inj_en_q;
    logic [ADDR_BITS-1:0] inj_addr_q;
    logic                 vld_p1;
    logic [DATA_BITS-1:0] exp_p1;
    logic [ADDR_BITS-1:0] addr_p1;
    logic [2:0]           elem_p1;
    logic [CNT_BITS-1:0]  fail_count_q;
    logic [ADDR_BITS-1:0] ff_addr_q;
    logic [2:0]           ff_elem_q;
    logic                 pass_q;
    logic                 is_rd, is_wr, last_op, at_term, launch, mismatch;
    logic                 busy, done, mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata, mem_rdata, wr_word;

    assign op     = elem_op(state);
    assign op_nxt = elem_op(state_nxt);
    // Two-op elements read in phase 0 and write in phase 1 at the same address.
    assign is_rd   = op.has_rd && !(op.has_wr && phase_q);
    assign is_wr   = op.has_wr && !(op.has_rd && !phase_q);
    assign last_op = op.has_wr ? is_wr : op.has_rd;
    assign at_term = op.down ? (addr_q == '0) : (addr_q == '1);
    assign launch  = (state == ST_IDLE) && bus.start;
    assign wr_word = (op.wr_inv ? ~bg_q : bg_q)
                   ^ {{(DATA_BITS-1){1'b0}}, inj_en_q && (addr_q == inj_addr_q)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_E0;
            ST_FLUSH: state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  if (last_op && at_term) state_nxt = next_elem(state);
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wr_word;
        case (state)
            ST_IDLE: begin
                mem_we    = bus.dir_we && !bus.start;
                mem_addr  = bus.dir_addr;
                mem_wdata = bus.dir_wdata;
            end
            ST_FIN:  done = 1'b1;
            default: begin
                busy   = 1'b1;
                mem_we = is_wr;
            end
        endcase
    end

    // Address counter restarts at the sweep origin of every new element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else if (state_nxt != state) begin
            addr_q  <= op_nxt.down ? '1 : '0;
            phase_q <= 1'b0;
        end else begin
            if (op.has_rd && op.has_wr) phase_q <= ~phase_q;
            if (last_op) addr_q <= op.down ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (launch) begin
            bg_q       <= bus.bg;
            inj_en_q   <= bus.inj_en;
            inj_addr_q <= bus.inj_addr;
        end
    end

    // ---- stage p1: read data returns; compare against word latched at read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= is_rd;
    end

    always_ff @(posedge clk) begin
        exp_p1  <= op.rd_inv ? ~bg_q : bg_q;
        addr_p1 <= addr_q;
        elem_p1 <= op.code;
    end

    assign mismatch = vld_p1 && (mem_rdata != exp_p1);

    // fail_count can never return to zero within a run, so zero marks "no
    // mismatch captured yet".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count_q <= '0;
            ff_addr_q    <= '0;
            ff_elem_q    <= '0;
            pass_q       <= 1'b0;
        end else if (launch) begin
            fail_count_q <= '0;
            ff_addr_q    <= '0;
            ff_elem_q    <= '0;
            pass_q       <= 1'b0;
        end else begin
            if (mismatch) begin
                if (fail_count_q != '1) fail_count_q <= fail_count_q + 1'b1;
                if (fail_count_q == '0) begin
                    ff_addr_q <= addr_p1;
                    ff_elem_q <= elem_p1;
                end
            end
            if (state == ST_FLUSH) pass_q <= (fail_count_q == '0) && !mismatch;
        end
    end

    memtest_march_engine_mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.rdata           = mem_rdata;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.pass            = pass_q;
    assign bus.fail_count      = fail_count_q;
    assign bus.first_fail_addr = ff_addr_q;
    assign bus.first_fail_elem = ff_elem_q;

endmodule

// File: tb/tb_memtest_march_engine.sv
// ----------------------------------------------------------------------------
// tb_memtest_march_engine
// Self-checking bench: a behavioural model (array of words plus a loop-level
// March C- evaluation per run) predicts every output; a negedge process
// compares the DUT against it, and literal expectations pin key scenarios.
// ----------------------------------------------------------------------------
module tb_memtest_march_engine;

    localparam int AB      = 4;
    localparam int DB      = 8;
    localparam int CB      = 8;
    localparam int N       = 1 << AB;
    localparam int RUN_LEN = 10 * N + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memtest_march_engine_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) bus ();

    memtest_march_engine #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [DB-1:0] m_mem [N];
    bit            m_vld [N];
    int            m_cyc;           // 0 idle, 1..RUN_LEN busy, RUN_LEN+1 done cycle
    logic [CB-1:0] m_fc,  r_fc;
    logic [AB-1:0] m_ffa, r_ffa;
    logic [2:0]    m_ffe, r_ffe;
    logic          m_pass, r_pass;
    logic [DB-1:0] m_rdata;
    bit            m_rdata_vld;

    // Evaluates a whole March C- run on the model array at once.
    function automatic void march_run(input logic [DB-1:0] b, input bit ie, input logic [AB-1:0] ia);
        int rd_kind[6];
        int wr_kind[6];
        bit down[6];
        int cnt;
        bit first;
        int a;
        logic [DB-1:0] w;
        rd_kind = '{-1, 0, 1, 0, 1, 0};
        wr_kind = '{0, 1, 0, 1, 0, -1};
        down    = '{0, 0, 0, 1, 1, 0};
        cnt = 0; first = 1'b1; r_ffa = '0; r_ffe = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = down[e] ? (N - 1 - k) : k;
                if (rd_kind[e] >= 0) begin
                    w = (rd_kind[e] == 1) ? ~b : b;
                    if (m_mem[a] !== w) begin
                        if (cnt < (1 << CB) - 1) cnt++;
                        if (first) begin
                            r_ffa = a[AB-1:0];
                            r_ffe = e[2:0];
                            first = 1'b0;
                        end
                    end
                end
                if (wr_kind[e] >= 0) begin
                    w = (wr_kind[e] == 1) ? ~b : b;
                    if (ie && a == int'(ia)) w[0] = ~w[0];
                    m_mem[a] = w;
                    m_vld[a] = 1'b1;
                end
            end
        end
        r_fc   = cnt[CB-1:0];
        r_pass = (cnt == 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (m_cyc != 0) for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
            m_cyc = 0; m_fc = '0; m_ffa = '0; m_ffe = '0; m_pass = 1'b0;
            m_rdata = '0; m_rdata_vld = 1'b1;
        end else if (m_cyc == 0) begin
            m_rdata     = m_mem[bus.dir_addr];
            m_rdata_vld = m_vld[bus.dir_addr];
            if (bus.start) begin
                march_run(bus.bg, bus.inj_en, bus.inj_addr);
                m_fc = '0; m_ffa = '0; m_ffe = '0; m_pass = 1'b0;
                m_cyc = 1;
            end else if (bus.dir_we) begin
                m_mem[bus.dir_addr] = bus.dir_wdata;
                m_vld[bus.dir_addr] = 1'b1;
            end
        end else begin
            m_rdata_vld = 1'b0;
            if (m_cyc == RUN_LEN) begin
                m_fc = r_fc; m_ffa = r_ffa; m_ffe = r_ffe; m_pass = r_pass;
            end
            m_cyc = (m_cyc == RUN_LEN + 1) ? 0 : m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_cyc >= 1 && m_cyc <= RUN_LEN));
            chk("done", 32'(bus.done), 32'(m_cyc == RUN_LEN + 1));
            if (m_cyc == 0 || m_cyc == RUN_LEN + 1) begin
                chk("fail_count", 32'(bus.fail_count), 32'(m_fc));
                chk("pass", 32'(bus.pass), 32'(m_pass));
                chk("first_fail_addr", 32'(bus.first_fail_addr), 32'(m_ffa));
                chk("first_fail_elem", 32'(bus.first_fail_elem), 32'(m_ffe));
            end
            if (m_rdata_vld) chk("rdata", 32'(bus.rdata), 32'(m_rdata));
        end
    end

    // ---------------- stimulus ----------------
    // Launches a run and returns on the negedge of the done cycle.
    task automatic run_bist(input logic [DB-1:0] b, input bit ie, input logic [AB-1:0] ia,
                            input bit noisy, output int len);
        int guard;
        bit seen_done;
        guard = 0; seen_done = 1'b0; len = 0;
        @(negedge clk);
        bus.bg = b; bus.inj_en = ie; bus.inj_addr = ia; bus.start = 1'b1; bus.dir_we = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!seen_done && guard < 400) begin
            if (bus.busy) begin
                len++;
                if (noisy) begin
                    bus.start     = 1'($urandom_range(0, 1));
                    bus.dir_we    = 1'($urandom_range(0, 1));
                    bus.dir_addr  = 4'd9;
                    bus.dir_wdata = 8'hFF;
                    bus.bg        = 8'($urandom);
                    bus.inj_en    = 1'($urandom_range(0, 1));
                    bus.inj_addr  = 4'($urandom);
                end
            end
            if (bus.done) seen_done = 1'b1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        bus.start = 1'b0; bus.dir_we = 1'b0;
        chk("run_reaches_done", 32'(seen_done), 32'd1);
    endtask

    initial begin
        int len;
        logic [DB-1:0] b;
        bus.start = 1'b0; bus.bg = '0; bus.inj_en = 1'b0; bus.inj_addr = '0;
        bus.dir_we = 1'b0; bus.dir_addr = '0; bus.dir_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_rdata", 32'(bus.rdata), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Direct write then read of address 3
        @(negedge clk);
        bus.dir_we = 1'b1; bus.dir_addr = 4'd3; bus.dir_wdata = 8'hA5;
        @(negedge clk);
        bus.dir_we = 1'b0;
        @(negedge clk);
        chk("direct_read_a5", 32'(bus.rdata), 32'hA5);

        // Random direct traffic
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.dir_we    = 1'($urandom_range(0, 1));
            bus.dir_addr  = 4'($urandom);
            bus.dir_wdata = 8'($urandom);
        end
        @(negedge clk);
        bus.dir_we = 1'b0;

        // Clean run
        run_bist(8'h00, 1'b0, 4'd0, 1'b0, len);
        chk("clean_len", 32'(len), 32'd161);
        chk("clean_pass", 32'(bus.pass), 32'd1);
        chk("clean_fail_count", 32'(bus.fail_count), 32'd0);

        // Injected fault at address 7
        run_bist(8'h3C, 1'b1, 4'd7, 1'b0, len);
        chk("inj_len", 32'(len), 32'd161);
        chk("inj_first_addr", 32'(bus.first_fail_addr), 32'd7);
        chk("inj_first_elem", 32'(bus.first_fail_elem), 32'd1);
        chk("inj_fail_count", 32'(bus.fail_count), 32'd5);
        chk("inj_pass", 32'(bus.pass), 32'd0);

        // Inputs toggled while busy are ignored
        run_bist(8'h3C, 1'b0, 4'd0, 1'b1, len);
        chk("noisy_len", 32'(len), 32'd161);
        chk("noisy_pass", 32'(bus.pass), 32'd1);
        @(negedge clk);
        bus.dir_addr = 4'd9;
        @(negedge clk);
        chk("addr9_after_run", 32'(bus.rdata), 32'h3C);

        // Randomised runs
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            run_bist(b, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, len);
            chk("rand_len", 32'(len), 32'd161);
        end

        // Asynchronous reset with non-zero status present
        run_bist(8'($urandom), 1'b1, 4'($urandom), 1'b0, len);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy", 32'(bus.busy), 32'd0);
        chk("areset_done", 32'(bus.done), 32'd0);
        chk("areset_pass", 32'(bus.pass), 32'd0);
        chk("areset_fail_count", 32'(bus.fail_count), 32'd0);
        chk("areset_first_addr", 32'(bus.first_fail_addr), 32'd0);
        chk("areset_first_elem", 32'(bus.first_fail_elem), 32'd0);
        chk("areset_rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset 50 cycles into an injected run, then a full clean run
        @(negedge clk);
        bus.bg = 8'($urandom); bus.inj_en = 1'b1; bus.inj_addr = 4'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (49) @(negedge clk);
        chk("midrun_fail_seen", 32'(bus.fail_count), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", 32'(bus.busy), 32'd0);
        chk("midrun_reset_fail_count", 32'(bus.fail_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_bist(8'($urandom), 1'b0, 4'd0, 1'b0, len);
        chk("after_reset_len", 32'(len), 32'd161);
        chk("after_reset_pass", 32'(bus.pass), 32'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memtest_march_engine.md
# memtest_march_engine

Parametrised successor to the on-chip memory test top. It wraps a register-file memory array with two modes. In direct mode the host writes and reads the array cycle by cycle. In BIST mode a built-in March C- engine sweeps every address, compares the data it reads back, and records pass/fail status. It sits between the chip pins and the memory array, and lets silicon bring-up test the array without per-address pin traffic.

## Interface
- ADDR_BITS, 4: address width; depth N = 2^ADDR_BITS.
- DATA_BITS, 8: word width.
- CNT_BITS, 8: width of the saturating failure counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level sampled in IDLE; launches a BIST run.
- bg  in  DATA_BITS  data background. "0" = bg, "1" = ~bg. Sampled at start.
- inj_en  in  1  fault injection enable, sampled at start.
- inj_addr  in  ADDR_BITS  injected fault address, sampled at start.
- dir_we  in  1  direct write enable; honoured only in IDLE.
- dir_addr  in  ADDR_BITS  direct address; honoured only in IDLE.
- dir_wdata  in  DATA_BITS  direct write data.
- rdata  out  DATA_BITS  registered array read data; reset 0.
- busy  out  1  BIST run in progress; reset 0.
- done  out  1  one-cycle pulse at run end; reset 0.
- pass  out  1  last run had zero mismatches; held until the next start; reset 0.
- fail_count  out  CNT_BITS  mismatches in the last run, saturating at all-ones; reset 0.
- first_fail_addr  out  ADDR_BITS  address of the first mismatch; reset 0.
- first_fail_elem  out  3  march element (1..5) of the first mismatch; reset 0.

## Operation
- Array write is synchronous. Read is registered: rdata = mem[addr] one cycle after the address is presented. The array has no reset.
- The address/we/wdata mux selects direct inputs in IDLE and engine outputs otherwise. rdata always shows the array read port.
- FSM states: IDLE, E0, E1, E2, E3, E4, E5, FLUSH, FIN.
  - E0: ⇑ w0.
  - E1: ⇑ (r0, w1).
  - E2: ⇑ (r1, w0).
  - E3: ⇓ (r0, w1).
  - E4: ⇓ (r1, w0).
  - E5: ⇑ r0.
- E1–E4 use a phase bit: the read cycle, then the write cycle at the same address. The address advances after the write.
- Up sweeps run 0→N-1; down sweeps run N-1→0. Each element exits when the address counter reaches its terminal value.
- The compare happens in the cycle after each read, against the expected word latched with that read.
- On a mismatch:
  - fail_count increments (saturating).
  - If this is the first mismatch of the run, first_fail_addr and first_fail_elem are captured.
- Fault injection: with inj_en set, every engine write to inj_addr has bit 0 inverted.
- IDLE with start=1: clear fail_count, first_fail_*, and pass; latch bg, inj_en, inj_addr; go to E0. dir_we in the same cycle is dropped.
- FLUSH: performs the final compare. FIN: done=1; pass=(fail_count==0); return to IDLE.
- start, dir_we and dir_addr are ignored while busy.
- rst_n low at any time: FSM goes to IDLE and all outputs go to their reset values. Memory contents are undefined-but-unchanged.

## Timing
- start sampled at edge k. The first E0 write happens in cycle k+1.
- Operation cycles total 10N: E0 N, E1–E4 2N each, E5 N. FLUSH adds 1 cycle.
- busy is high for exactly 10N+1 cycles. done pulses in the following cycle (FIN, busy=0).
- Status outputs update in the FIN cycle and are stable from then on.
- A new start is accepted in the cycle after FIN.
- Direct read latency: 1 cycle. A read of an address written in the previous cycle returns the new data.

## Structure
- The shared header common.vh holds:
  - default ADDR_BITS and DATA_BITS;
  - state encodings;
  - march element codes and their direction/op table.
- One sub-module: mem_array. It is the parametrised register file with synchronous write and registered read.
- The engine FSM, address counter and comparator stay in memtest_march_engine.

## Test plan
All scenarios use ADDR_BITS=4 (N=16) and DATA_BITS=8.
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately (asynchronous reset).
- Direct access: IDLE, write 0xA5 to address 3, then present address 3 → rdata=0xA5 exactly one cycle later.
- Clean BIST: bg=0x00, inj_en=0, pulse start → busy high 161 cycles, done pulses once, pass=1, fail_count=0.
- Injected fault: bg=0x3C, inj_en=1, inj_addr=7.
  - E1 reads 0x3D where 0x3C is expected.
  - Required result: first_fail_addr=7, first_fail_elem=1, fail_count=5, pass=0.
- Ignored inputs while busy: toggle start and dir_we(addr 9, 0xFF) while busy → run length stays 161 cycles. After done, a direct read of address 9 returns 0x3C (the bg value used for that run).
- Reset mid-run: drop rst_n at cycle 50 of a run → busy=0 and fail_count=0 at once. A subsequent start runs the full 161 cycles with pass=1.
